byte_descrambler: RTL and testbench

BYTE_DESCRAMBLER -- requirements
Module: byte_descrambler

---
 rtl/byte_descrambler_if.sv | 24 ++
 rtl/byte_descrambler.sv | 105 ++++++++++
 tb/tb_byte_descrambler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_descrambler_if.sv
// Byte stream bus for the XOR-keystream descrambler: seed control, input and output
// handshakes, and status.
interface byte_descrambler_if;
  logic        seed_load;
  logic [7:0]  seed;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        locked;
  logic [15:0] byte_count;

  modport master (
    output seed_load, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, locked, byte_count
  );

  modport slave (
    input  seed_load, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, locked, byte_count
  );
endinterface

// File: rtl/byte_descrambler.sv
// Descrambles an 8-bit XOR keystream generated by an x^8+x^6+x^5+x^4+1 LFSR that
// advances one byte (8 steps) per accepted input; single registered output stage.
module byte_descrambler (
  input logic              clk,
  input logic              rst,
  byte_descrambler_if.slave bus
);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  lfsr_r;
  logic [7:0]  lfsr_next_s;
  logic [7:0]  out_data_r;
  logic [7:0]  out_data_next_s;
  logic        out_valid_r;
  logic        out_valid_next_s;
  logic [15:0] count_r;
  logic [15:0] count_next_s;
  logic        in_ready_s;
  logic        accept_s;

  function automatic logic [7:0] lfsr_step8(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[6:0], t[7] ^ t[5] ^ t[4] ^ t[3]};
    end
    return t;
  endfunction

  // A pending output blocks new input unless the sink takes it this same cycle.
  assign in_ready_s = (state_r == RUN) && !bus.seed_load && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Next-state logic for the lock FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      UNLOCKED: begin
        if (bus.seed_load) begin
          state_next_s = RUN;
        end else begin
          state_next_s = UNLOCKED;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = UNLOCKED;
    endcase
  end

  // Next values for keystream, counter and output stage; an all-zero seed would lock up.
  always_comb begin
    lfsr_next_s      = lfsr_r;
    count_next_s     = count_r;
    out_data_next_s  = out_data_r;
    out_valid_next_s = out_valid_r;
    if (bus.seed_load) begin
      lfsr_next_s  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
      count_next_s = 16'h0000;
    end else if (accept_s) begin
      lfsr_next_s  = lfsr_step8(lfsr_r);
      count_next_s = count_r + 16'h0001;
    end else begin
      lfsr_next_s  = lfsr_r;
      count_next_s = count_r;
    end
    if (accept_s) begin
      out_data_next_s  = bus.in_data ^ lfsr_r;
      out_valid_next_s = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_next_s = 1'b0;
    end else begin
      out_valid_next_s = out_valid_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= UNLOCKED;
      lfsr_r      <= 8'h01;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      count_r     <= 16'h0000;
    end else begin
      state_r     <= state_next_s;
      lfsr_r      <= lfsr_next_s;
      out_data_r  <= out_data_next_s;
      out_valid_r <= out_valid_next_s;
      count_r     <= count_next_s;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.locked     = (state_r == RUN);
  assign bus.byte_count = count_r;

endmodule

// File: tb/tb_byte_descrambler.sv
// Bench for byte_descrambler: directed scenario tasks plus a negedge scoreboard that
// predicts every output byte, in_ready, locked and byte_count from its own LFSR model.
module tb_byte_descrambler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   assertions = 0;
  int   failures   = 0;

  logic [7:0]  sb_q[$];
  logic [7:0]  m_s      = 8'h01;
  logic [15:0] m_cnt    = 16'h0000;
  logic        m_locked = 1'b0;
  logic        exp_ready;

  byte_descrambler_if bus();

  byte_descrambler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ks_adv(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int k = 0; k < 8; k++) t = {t[6:0], ^(t & 8'hB8)};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [7:0] v);
    bus.seed_load = 1'b1;
    bus.seed      = v;
    tick();
    bus.seed_load = 1'b0;
  endtask

  // Scoreboard: checks state at each negedge, then models the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_s      = 8'h01;
      m_cnt    = 16'h0000;
      m_locked = 1'b0;
    end else begin
      exp_ready = m_locked && !bus.seed_load && (sb_q.size() == 0 || bus.out_ready);
      assertions++;
      if (bus.in_ready !== exp_ready) begin
        failures++;
        $display("FAIL sb_in_ready: got %b expected %b at %0t", bus.in_ready, exp_ready, $time);
      end
      assertions++;
      if (bus.out_valid !== (sb_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_out_valid: got %b expected %b at %0t", bus.out_valid, (sb_q.size() != 0), $time);
      end
      assertions++;
      if (bus.locked !== m_locked) begin
        failures++;
        $display("FAIL sb_locked: got %b expected %b at %0t", bus.locked, m_locked, $time);
      end
      assertions++;
      if (bus.byte_count !== m_cnt) begin
        failures++;
        $display("FAIL sb_byte_count: got %h expected %h at %0t", bus.byte_count, m_cnt, $time);
      end
      if (sb_q.size() != 0) begin
        assertions++;
        if (bus.out_data !== sb_q[0]) begin
          failures++;
          $display("FAIL sb_out_data: got %h expected %h at %0t", bus.out_data, sb_q[0], $time);
        end
        if (bus.out_ready) void'(sb_q.pop_front());
      end
      if (bus.seed_load) begin
        m_s      = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        m_cnt    = 16'h0000;
        m_locked = 1'b1;
      end else if (bus.in_valid && exp_ready) begin
        sb_q.push_back(bus.in_data ^ m_s);
        m_s   = ks_adv(m_s);
        m_cnt = m_cnt + 16'h0001;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #2;
    assertions++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    assertions++;
    if (bus.out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
    assertions++;
    if (bus.byte_count !== 16'h0000) begin failures++; $display("FAIL rst_byte_count: got %h expected 0000", bus.byte_count); end
    assertions++;
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL rst_locked: got %b expected 0", bus.locked); end
    assertions++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      assertions++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.locked !== 1'b0) begin
        failures++;
        $display("FAIL unlocked_idle: got rdy=%b vld=%b lck=%b expected 0 0 0", bus.in_ready, bus.out_valid, bus.locked);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic(input logic [7:0] sd);
    bus.out_ready = 1'b1;
    load_seed(sd);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    assertions++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready seed %h: got %b expected 1", sd, bus.in_ready); end
    tick();
    bus.in_data = 8'h1C;
    assertions++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA4) begin
      failures++;
      $display("FAIL basic_byte0 seed %h: got vld=%b data=%h expected 1 a4", sd, bus.out_valid, bus.out_data);
    end
    tick();
    bus.in_valid = 1'b0;
    assertions++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL basic_byte1 seed %h: got vld=%b data=%h expected 1 00", sd, bus.out_valid, bus.out_data);
    end
    assertions++;
    if (bus.byte_count !== 16'd2) begin failures++; $display("FAIL basic_count seed %h: got %0d expected 2", sd, bus.byte_count); end
    tick();
    assertions++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain seed %h: got %b expected 0", sd, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    load_seed(8'h3C);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    tick();
    bus.in_data = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      assertions++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h2D) begin
        failures++;
        $display("FAIL stall_hold: got rdy=%b vld=%b data=%h expected 0 1 2d", bus.in_ready, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    assertions++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    assertions++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== (8'h22 ^ ks_adv(8'h3C))) begin
      failures++;
      $display("FAIL stall_takeover: got vld=%b data=%h expected 1 %h", bus.out_valid, bus.out_data, 8'h22 ^ ks_adv(8'h3C));
    end
    tick();
  endtask

  task automatic test_seed_resync();
    bus.out_ready = 1'b1;
    load_seed(8'h77);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    tick();
    bus.seed_load = 1'b1;
    bus.seed      = 8'h9D;
    bus.in_data   = 8'h5E;
    bus.out_ready = 1'b0;
    #1;
    assertions++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL resync_block: got %b expected 0", bus.in_ready); end
    tick();
    bus.seed_load = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    assertions++;
    if (bus.in_ready !== 1'b1 || bus.byte_count !== 16'd0 || bus.out_data !== 8'hB4 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL resync_pending: got rdy=%b cnt=%0d vld=%b data=%h expected 1 0 1 b4", bus.in_ready, bus.byte_count, bus.out_valid, bus.out_data);
    end
    tick();
    bus.in_valid = 1'b0;
    assertions++;
    if (bus.out_data !== 8'hC3 || bus.byte_count !== 16'd1) begin
      failures++;
      $display("FAIL resync_newks: got data=%h cnt=%0d expected c3 1", bus.out_data, bus.byte_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      bus.seed_load = ($urandom_range(0, 15) == 0);
      bus.seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.seed_load = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
    tick();
    assertions++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL stream_drain: got %0d bytes left expected 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    load_seed(8'h42);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    assertions++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre: got %b expected 1", bus.out_valid); end
    #1;
    rst = 1'b1;
    #1;
    assertions++;
    if (bus.out_valid !== 1'b0 || bus.locked !== 1'b0 || bus.byte_count !== 16'd0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: got vld=%b lck=%b cnt=%0d data=%h rdy=%b expected 0 0 0 00 0",
               bus.out_valid, bus.locked, bus.byte_count, bus.out_data, bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      assertions++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL arst_relock: got rdy=%b vld=%b expected 0 0", bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.seed_load = 1'b0;
    bus.seed      = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic(8'h01);
    test_basic(8'h00);
    test_backpressure();
    test_seed_resync();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
